// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control sequencer and its decoder:
// internal opcode codes, sequencer states, trap causes and PC-select codes.
// Opcodes are the core's compacted 7-bit codes; anything above SYSTEM is illegal.
package cpu_control_fsm_pkg;

  localparam int OPCODE_W_DEF    = 7;
  localparam int MEM_TIMEOUT_DEF = 16;

  // Compacted internal opcode field, OP_IMM..SYSTEM
  localparam logic [6:0] OPC_OP_IMM   = 7'd0;
  localparam logic [6:0] OPC_OP       = 7'd1;
  localparam logic [6:0] OPC_LUI      = 7'd2;
  localparam logic [6:0] OPC_AUIPC    = 7'd3;
  localparam logic [6:0] OPC_JAL      = 7'd4;
  localparam logic [6:0] OPC_JALR     = 7'd5;
  localparam logic [6:0] OPC_BRANCH   = 7'd6;
  localparam logic [6:0] OPC_LOAD     = 7'd7;
  localparam logic [6:0] OPC_STORE    = 7'd8;
  localparam logic [6:0] OPC_MISC_MEM = 7'd9;
  localparam logic [6:0] OPC_SYSTEM   = 7'd10;

  // PC next-value select
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PC_SEL_REL = 2'b01;  // pc + imm
  localparam logic [1:0] PC_SEL_REG = 2'b10;  // rs + imm

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10,
    CAUSE_SYSTEM  = 2'b11
  } cause_t;

  // Instructions that produce a register result
  function automatic logic writes_reg(input logic [6:0] op);
    case (op)
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_LOAD: writes_reg = 1'b1;
      default:                     writes_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Handshake and control bundle between the sequencer and the rest of the core.
// master = the sequencer (drives requests/enables), slave = datapath/bus side.
// Pure wiring, no latency; requests are plain levels acknowledged by *_ack.
interface cpu_control_fsm_if
  import cpu_control_fsm_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                imem_ack;
  logic                dmem_ack;
  logic                branch_taken;
  logic                imem_req;
  logic                dmem_req;
  logic                dmem_we;
  logic                dec_enable;
  logic                alu_enable;
  logic                reg_we;
  logic                pc_we;
  logic [1:0]          pc_sel;
  logic                retire;
  logic [31:0]         instret;
  logic                trap;
  logic [1:0]          trap_cause;

  modport master (
    input  run, opcode, imem_ack, dmem_ack, branch_taken,
    output imem_req, dmem_req, dmem_we, dec_enable, alu_enable, reg_we,
           pc_we, pc_sel, retire, instret, trap, trap_cause
  );

  modport slave (
    output run, opcode, imem_ack, dmem_ack, branch_taken,
    input  imem_req, dmem_req, dmem_we, dec_enable, alu_enable, reg_we,
           pc_we, pc_sel, retire, instret, trap, trap_cause
  );
endinterface

// File: rtl/cpu_control_fsm_bus_timer.sv
// Wait counter for FETCH/MEMORY bus handshakes; expired flags the last allowed cycle.
// Registered count, combinational expired; clear wins over count_en.
// No backpressure: counts every enabled cycle and holds at the last value.
module bus_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int            CW   = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count waiting cycles; stop at the last allowed value so it never wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = count_en && (count == LAST);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK.
// ALU-type instruction 4 cycles with immediate acks, LOAD/STORE 5; TRAP is sticky until reset.
// Waits on imem_ack/dmem_ack with a bounded timeout; run is honoured only in IDLE and WRITEBACK.
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int OPCODE_W    = OPCODE_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  cpu_control_fsm_if.master bus
);

  state_t              state, next_state;
  cause_t              cause_q, next_cause;
  logic [OPCODE_W-1:0] op_q;
  logic [31:0]         instret_q;
  logic                waiting;
  logic                expired;

  logic                imem_req, dmem_req, dmem_we, dec_enable, alu_enable;
  logic                reg_we, pc_we, retire, trap;
  logic [1:0]          pc_sel;

  // The counter sits at zero outside the two wait states, so it starts from zero on entry
  assign waiting = (state == S_FETCH) || (state == S_MEMORY);

  bus_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_bus_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (!waiting),
    .count_en (waiting),
    .expired  (expired)
  );

  // State and trap-cause registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= next_state;
      cause_q <= next_cause;
    end
  end

  // Capture the opcode while it is valid so later states decode from op_q only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
    end else if (state == S_DECODE) begin
      op_q <= bus.opcode;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instret_q <= '0;
    end else if (state == S_WRITEBACK) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  // Next-state and control-output decode
  always_comb begin
    next_state = state;
    next_cause = cause_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dec_enable = 1'b0;
    alu_enable = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    retire     = 1'b0;
    trap       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.run) next_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // An ack on the last allowed cycle still completes the fetch
        if (bus.imem_ack) begin
          next_state = S_DECODE;
        end else if (expired) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        dec_enable = 1'b1;
        if (bus.opcode > OPCODE_W'(OPC_SYSTEM)) begin
          next_state = S_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end else begin
          next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_enable = 1'b1;
        case (op_q)
          OPC_LOAD, OPC_STORE: next_state = S_MEMORY;
          OPC_SYSTEM: begin
            next_state = S_TRAP;
            next_cause = CAUSE_SYSTEM;
          end
          default:             next_state = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OPC_STORE);
        if (bus.dmem_ack) begin
          next_state = S_WRITEBACK;
        end else if (expired) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_WRITEBACK: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        reg_we = writes_reg(op_q);
        // branch_taken is the ALU's registered compare result, only consulted here
        if (op_q == OPC_JAL || (op_q == OPC_BRANCH && bus.branch_taken)) begin
          pc_sel = PC_SEL_REL;
        end else if (op_q == OPC_JALR) begin
          pc_sel = PC_SEL_REG;
        end
        next_state = bus.run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req   = imem_req;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.dec_enable = dec_enable;
  assign bus.alu_enable = alu_enable;
  assign bus.reg_we     = reg_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.retire     = retire;
  assign bus.instret    = instret_q;
  assign bus.trap       = trap;
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: each instruction is expanded into an expected
// cycle-by-cycle trace (inputs to drive + outputs required) from the sequencing rules,
// then replayed against the DUT with unrelated inputs randomized every cycle.
module tb_cpu_control_fsm;
  import cpu_control_fsm_pkg::*;

  localparam int TO = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  cpu_control_fsm_if #(.OPCODE_W(7)) bus_if ();

  cpu_control_fsm #(.MEM_TIMEOUT(TO), .OPCODE_W(7)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if.master)
  );

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       dec;
    logic       alu;
    logic       reg_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       retire;
    logic       trap;
    logic [1:0] cause;
  } obs_t;

  typedef struct packed {
    logic       run;
    logic       iack;
    logic       dack;
    logic       bt;
    logic [6:0] opc;
    obs_t       exp;
  } step_t;

  step_t       q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_instret = '0;
  string       tag = "init";
  int          cyc = 0;

  function automatic obs_t sample();
    obs_t o;
    o.imem_req = bus_if.imem_req;
    o.dmem_req = bus_if.dmem_req;
    o.dmem_we  = bus_if.dmem_we;
    o.dec      = bus_if.dec_enable;
    o.alu      = bus_if.alu_enable;
    o.reg_we   = bus_if.reg_we;
    o.pc_we    = bus_if.pc_we;
    o.pc_sel   = bus_if.pc_sel;
    o.retire   = bus_if.retire;
    o.trap     = bus_if.trap;
    o.cause    = bus_if.trap_cause;
    return o;
  endfunction

  // A cycle whose inputs are irrelevant to the required outputs
  function automatic step_t noise();
    step_t s;
    s.run  = 1'($urandom_range(0, 1));
    s.iack = 1'($urandom_range(0, 1));
    s.dack = 1'($urandom_range(0, 1));
    s.bt   = 1'($urandom_range(0, 1));
    s.opc  = 7'($urandom_range(0, 127));
    s.exp  = '0;
    return s;
  endfunction

  function automatic void add_idle(input logic run);
    step_t s;
    s = noise();
    s.run = run;
    q.push_back(s);
  endfunction

  function automatic void add_trap(input logic [1:0] cause);
    step_t s;
    for (int n = 0; n < 4; n++) begin
      s = noise();
      s.exp.trap  = 1'b1;
      s.exp.cause = cause;
      q.push_back(s);
    end
  endfunction

  // One instruction starting in FETCH; fdly/mdly = cycles before the ack (>= TO: never)
  function automatic void add_instr(input logic [6:0] op, input logic bt,
                                    input int fdly, input int mdly, input logic run_after);
    step_t s;
    for (int k = 0; k < TO && k <= fdly; k++) begin
      s = noise();
      s.iack = (k == fdly);
      s.exp.imem_req = 1'b1;
      q.push_back(s);
    end
    if (fdly >= TO) begin add_trap(2'b10); return; end
    s = noise();
    s.opc = op;
    s.exp.dec = 1'b1;
    q.push_back(s);
    if (op > 7'd10) begin add_trap(2'b01); return; end
    s = noise();
    s.exp.alu = 1'b1;
    q.push_back(s);
    if (op == OPC_SYSTEM) begin add_trap(2'b11); return; end
    if (op == OPC_LOAD || op == OPC_STORE) begin
      for (int k = 0; k < TO && k <= mdly; k++) begin
        s = noise();
        s.dack = (k == mdly);
        s.exp.dmem_req = 1'b1;
        s.exp.dmem_we  = (op == OPC_STORE);
        q.push_back(s);
      end
      if (mdly >= TO) begin add_trap(2'b10); return; end
    end
    s = noise();
    s.run = run_after;
    s.bt  = bt;
    s.exp.pc_we  = 1'b1;
    s.exp.retire = 1'b1;
    s.exp.reg_we = !(op inside {OPC_BRANCH, OPC_STORE, OPC_MISC_MEM});
    if (op == OPC_JAL || (op == OPC_BRANCH && bt)) s.exp.pc_sel = 2'b01;
    else if (op == OPC_JALR)                      s.exp.pc_sel = 2'b10;
    else                                          s.exp.pc_sel = 2'b00;
    q.push_back(s);
  endfunction

  task automatic run_steps(input int n);
    step_t s;
    obs_t  o;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      @(negedge clock);
      bus_if.run          = s.run;
      bus_if.imem_ack     = s.iack;
      bus_if.dmem_ack     = s.dack;
      bus_if.branch_taken = s.bt;
      bus_if.opcode       = s.opc;
      #1;
      o = sample();
      checks++;
      assert (o === s.exp) else begin
        errors++;
        $error("FAIL %s step %0d outputs: got %h expected %h", tag, cyc, o, s.exp);
      end
      checks++;
      assert (bus_if.instret === model_instret) else begin
        errors++;
        $error("FAIL %s step %0d instret: got %0d expected %0d", tag, cyc, bus_if.instret, model_instret);
      end
      if (s.exp.retire) model_instret = model_instret + 32'd1;
      cyc++;
    end
  endtask

  task automatic run_all();
    run_steps(q.size());
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge
  task automatic do_reset();
    obs_t o;
    #2;
    reset_n    = 1'b0;
    bus_if.run = 1'b0;
    #1;
    o = sample();
    checks++;
    assert (o === obs_t'('0)) else begin
      errors++;
      $error("FAIL %s reset outputs: got %h expected 0", tag, o);
    end
    checks++;
    assert (bus_if.instret === 32'd0) else begin
      errors++;
      $error("FAIL %s reset instret: got %0d expected 0", tag, bus_if.instret);
    end
    model_instret = '0;
    q.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic r;
    bus_if.run          = 1'b0;
    bus_if.imem_ack     = 1'b0;
    bus_if.dmem_ack     = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.opcode       = '0;

    tag = "reset";
    do_reset();

    tag = "t1_op";
    add_idle(1'b1);
    add_instr(OPC_OP, 1'b0, 0, 0, 1'b0);
    add_idle(1'b0);
    run_all();

    tag = "t2_load";
    add_idle(1'b1);
    add_instr(OPC_LOAD, 1'b0, 0, 3, 1'b1);
    tag = "t3_branch";
    add_instr(OPC_BRANCH, 1'b1, 1, 0, 1'b1);
    add_instr(OPC_BRANCH, 1'b0, 0, 0, 1'b1);
    add_instr(OPC_JALR, 1'b1, 2, 0, 1'b1);
    add_instr(OPC_JAL, 1'b0, 0, 0, 1'b0);
    add_idle(1'b0);
    run_all();

    tag = "t4_last_ack";
    add_idle(1'b1);
    add_instr(OPC_OP_IMM, 1'b0, TO - 1, 0, 1'b1);
    add_instr(OPC_STORE, 1'b0, 0, TO - 1, 1'b0);
    add_idle(1'b0);
    run_all();

    tag = "random";
    add_idle(1'b1);
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      add_instr(7'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), r);
      if (!r) begin
        add_idle(1'b0);
        add_idle(1'b1);
      end
    end
    add_instr(OPC_MISC_MEM, 1'b0, 0, 0, 1'b0);
    add_idle(1'b0);
    run_all();

    tag = "t4_fetch_timeout";
    add_idle(1'b1);
    add_instr(OPC_OP, 1'b0, TO, 0, 1'b1);
    run_all();
    do_reset();

    tag = "t4_mem_timeout";
    add_idle(1'b1);
    add_instr(OPC_LOAD, 1'b0, 0, TO, 1'b1);
    run_all();
    do_reset();

    tag = "t5_illegal";
    add_idle(1'b1);
    add_instr(7'b0001111, 1'b0, 0, 0, 1'b1);
    run_all();
    do_reset();

    tag = "t5_system";
    add_idle(1'b1);
    add_instr(OPC_AUIPC, 1'b0, 0, 0, 1'b1);
    add_instr(OPC_SYSTEM, 1'b0, 0, 0, 1'b1);
    run_all();
    do_reset();

    tag = "t6_reset_mem";
    add_idle(1'b1);
    add_instr(OPC_LUI, 1'b0, 0, 0, 1'b1);
    add_instr(OPC_LOAD, 1'b0, 0, 10, 1'b1);
    run_steps(1 + 4 + 3 + 5);
    do_reset();
    tag = "t6_idle_hold";
    for (int i = 0; i < 5; i++) add_idle(1'b0);
    run_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
